// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default
// byte width and launch-timeout counter width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    ACTIVE = 2'b10,
    DONE   = 2'b11
  } arb_state_t;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned TMO_CNT_W       = 16;

endpackage

// File: rtl/uart_tx_arb_rr_picker.sv
// Combinational round-robin selector: first active request after ptr,
// wrapping modulo NUM_REQ. Reusable for any shared peripheral.
module rr_picker #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 valid
);

  // Scan from lowest to highest priority so the last hit (ptr+1) wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      logic [IDX_WIDTH-1:0] k;
      k = IDX_WIDTH'((32'(ptr) + NUM_REQ - i) % NUM_REQ);
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = k;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Define UART_TX_ARB_TIMEOUT_EN to abort launches that never see tx_busy.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int unsigned IDX_WIDTH      = $clog2(NUM_REQ),
  parameter int unsigned LAUNCH_TIMEOUT = 65535
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic                          err_o,
  output logic                          busy_o,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || LAUNCH_TIMEOUT < 1 ||
      LAUNCH_TIMEOUT >= (1 << TMO_CNT_W)) begin : g_bad_cfg
    $error("uart_tx_arb: illegal NUM_REQ or LAUNCH_TIMEOUT");
  end

  localparam logic [IDX_WIDTH-1:0] PTR_RST = IDX_WIDTH'(NUM_REQ - 1);

  arb_state_t             state_q, state_d;
  logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   start_q, start_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;

  logic [NUM_REQ-1:0]     pick_gnt;
  logic [IDX_WIDTH-1:0]   pick_idx;
  logic                   pick_valid;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(LAUNCH_TIMEOUT - 1);
  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
`endif

  rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_picker (
    .req   (req_i),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    ack_d   = '0;
    start_d = start_q;
    data_d  = data_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          idx_d   = pick_idx;
          data_d  = DATA_WIDTH'(data_i >> (32'(pick_idx) * DATA_WIDTH));
          start_d = 1'b1;
          state_d = LAUNCH;
`ifdef UART_TX_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      LAUNCH: begin
        if (tx_busy) begin
          start_d = 1'b0;
          state_d = ACTIVE;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        // Abort releases the grant without ack but still rotates priority.
        else if (cnt_q == TMO_LAST) begin
          start_d = 1'b0;
          grant_d = '0;
          err_d   = 1'b1;
          ptr_d   = idx_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ACTIVE: begin
        if (!tx_busy) begin
          ack_d   = grant_q;
          state_d = DONE;
        end
      end
      DONE: begin
        grant_d = '0;
        ptr_d   = idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      idx_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      data_q  <= data_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign grant_o  = grant_q;
  assign ack_o    = ack_q;
  assign busy_o   = (state_q != IDLE);
  assign tx_start = start_q;
  assign tx_data  = data_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign err_o    = err_q;
`else
  assign err_o    = 1'b0;
`endif

endmodule
